// File: rtl/latch_pkg.sv
// Shared types and constants for the latch bank loader: state encoding,
// default timing, and the width helpers used to size counters.
package latch_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam int DEF_N_LATCH    = 8;
  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_STROBE_CYC = 2;
  localparam int DEF_HOLD_CYC   = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing one loader phase; expire is high in the
// last cycle of the phase (count == 1).
module phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt_q <= '0;
    else if (load)           cnt_q <= load_val;
    else if (cnt_q != '0)    cnt_q <= cnt_q - W'(1);
  end

  assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/latch_bank_loader.sv
// Walks an accepted word out to a bank of D latches one bit at a time,
// framing each latch's one-hot enable with d_out setup and hold.
module latch_bank_loader
  import latch_pkg::*;
#(
  parameter int N_LATCH    = DEF_N_LATCH,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_LATCH-1:0] in_data,
  output logic               d_out,
  output logic [N_LATCH-1:0] E_out,
  output logic               busy,
  output logic               done
);

  localparam int IW = clog2(N_LATCH);
  localparam int TW = clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);
  localparam logic [TW-1:0] S_VAL = TW'(SETUP_CYC);
  localparam logic [TW-1:0] T_VAL = TW'(STROBE_CYC);
  localparam logic [TW-1:0] H_VAL = TW'(HOLD_CYC);

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [N_LATCH-1:0] word_q, word_d;
  logic [N_LATCH-1:0] e_q, e_d;
  logic               d_q, d_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rdy_q, rdy_d;
  logic               tmr_load, tmr_expire;
  logic [TW-1:0]      tmr_val;

  phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    word_d   = word_q;
    tmr_load = 1'b0;
    case (state_q)
      IDLE: if (in_valid && rdy_q) begin
        word_d   = in_data;
        idx_d    = '0;
        state_d  = SETUP;
        tmr_load = 1'b1;
      end
      SETUP: if (tmr_expire) begin
        state_d  = STROBE;
        tmr_load = 1'b1;
      end
      STROBE: if (tmr_expire) begin
        state_d  = HOLD;
        tmr_load = 1'b1;
      end
      HOLD: if (tmr_expire) begin
        if (idx_q == IW'(N_LATCH - 1)) begin
          state_d = DONE;
        end else begin
          idx_d    = idx_q + IW'(1);
          state_d  = SETUP;
          tmr_load = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      SETUP:   tmr_val = S_VAL;
      STROBE:  tmr_val = T_VAL;
      default: tmr_val = H_VAL;
    endcase

    // Outputs are computed from the next state so they register on the
    // same edge as the state change; d_out only moves when entering SETUP.
    d_d = (state_d == SETUP) ? word_d[idx_d] : d_q;
    e_d = '0;
    if (state_d == STROBE) e_d[idx_d] = 1'b1;
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    rdy_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      e_q     <= '0;
      d_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      e_q     <= e_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready = rdy_q;
  assign d_out    = d_q;
  assign E_out    = e_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
